draw_blit_engine: RTL and testbench

DRAW_BLIT_ENGINE -- requirements
Module: draw_blit_engine

---
 rtl/draw_pkg.sv | 43 ++++
 rtl/draw_addr_gen.sv | 60 ++++++
 rtl/draw_blit_engine.sv | 256 +++++++++++++++++++++++++
 tb/tb_draw_blit_engine.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared definitions for the sprite blit engine: FSM state encoding, the
// per-stage pipeline control record and the sheet/screen address helpers.
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Control travelling alongside each pixel slot through the pipeline.
  typedef struct packed {
    logic vld;
    logic clip;
  } pipe_ctl_t;

  // Width used for all intermediate address arithmetic before truncation.
  localparam int unsigned CALC_W = 32;

  // Linear address of texel (sx, sy) of sprite idx, theme column th, in a
  // sheet that is size*themes texels wide.
  function automatic logic [CALC_W-1:0] sheet_addr(
    input logic [CALC_W-1:0] idx,
    input logic [CALC_W-1:0] sy,
    input logic [CALC_W-1:0] sx,
    input logic [CALC_W-1:0] th,
    input logic [CALC_W-1:0] size,
    input logic [CALC_W-1:0] themes
  );
    return (idx * size + sy) * size * themes + th * size + sx;
  endfunction

  // Linear framebuffer address of screen pixel (px, py) for a given pitch.
  function automatic logic [CALC_W-1:0] screen_addr(
    input logic [CALC_W-1:0] pitch,
    input logic [CALC_W-1:0] px,
    input logic [CALC_W-1:0] py
  );
    return pitch * py + px;
  endfunction

endpackage

// File: rtl/draw_addr_gen.sv
// Combinational address generator for the blit engine: sprite-sheet texel
// address (with tiling and optional horizontal mirror), framebuffer address
// and screen clip flag for one rectangle position.
// Optional feature macro: DRAW_BLIT_FLIP_EN (horizontal sprite mirroring).
module draw_addr_gen
  import draw_pkg::*;
#(
  parameter int SCREEN_WIDTH      = 320,
  parameter int SCREEN_HEIGHT     = 240,
  parameter int SPRITE_SIZE       = 32,
  parameter int THEMES            = 2,
  parameter int SPRITEBUF_A_WIDTH = 15,
  parameter int VRAM_A_WIDTH      = 17,
  parameter int TH_W              = 1
) (
  input  logic [9:0]                   i_x,
  input  logic [9:0]                   i_y,
  input  logic [9:0]                   i_pos_x,
  input  logic [9:0]                   i_pos_y,
  input  logic [4:0]                   i_sprite_index,
  input  logic [TH_W-1:0]              i_theme,
  input  logic                         i_flip_x,
  output logic [SPRITEBUF_A_WIDTH-1:0] o_sprite_addr,
  output logic [VRAM_A_WIDTH-1:0]      o_fb_addr,
  output logic                         o_clip
);

  localparam int SS_W = $clog2(SPRITE_SIZE);

  logic [SS_W-1:0]   w_sx_raw;
  logic [SS_W-1:0]   w_sx;
  logic [SS_W-1:0]   w_sy;
  logic [CALC_W-1:0] w_px;
  logic [CALC_W-1:0] w_py;

  // SPRITE_SIZE is a power of two, so the modulo is just the low bits.
  assign w_sx_raw = i_x[SS_W-1:0];
  assign w_sy     = i_y[SS_W-1:0];

`ifdef DRAW_BLIT_FLIP_EN
  // SPRITE_SIZE-1-sx equals the bitwise complement for a power-of-two size.
  assign w_sx = i_flip_x ? ~w_sx_raw : w_sx_raw;
`else
  logic w_unused_flip;
  assign w_unused_flip = i_flip_x;
  assign w_sx          = w_sx_raw;
`endif

  assign w_px = CALC_W'(i_pos_x) + CALC_W'(i_x);
  assign w_py = CALC_W'(i_pos_y) + CALC_W'(i_y);

  assign o_sprite_addr = SPRITEBUF_A_WIDTH'(sheet_addr(
    CALC_W'(i_sprite_index), CALC_W'(w_sy), CALC_W'(w_sx),
    CALC_W'(i_theme), CALC_W'(SPRITE_SIZE), CALC_W'(THEMES)));

  assign o_fb_addr = VRAM_A_WIDTH'(screen_addr(CALC_W'(SCREEN_WIDTH), w_px, w_py));

  assign o_clip = (w_px >= CALC_W'(SCREEN_WIDTH)) || (w_py >= CALC_W'(SCREEN_HEIGHT));

endmodule

// File: rtl/draw_blit_engine.sv
// Sprite blit engine: scans a rectangle, fetches tiled sprite texels from a
// synchronous sprite buffer and writes them to the framebuffer with clipping,
// colour-key transparency and fb_ready backpressure.
// Pipeline: counters -> p0 (sprite_addr) -> p1 (await sprite_data) -> p2 (fb write).
// Optional feature macro: DRAW_BLIT_FLIP_EN (flip_x mirrors the sprite).
module draw_blit_engine
  import draw_pkg::*;
#(
  parameter int SCREEN_WIDTH      = 320,
  parameter int SCREEN_HEIGHT     = 240,
  parameter int SPRITE_SIZE       = 32,
  parameter int THEMES            = 2,
  parameter int SPRITEBUF_A_WIDTH = 15,
  parameter int VRAM_A_WIDTH      = 17,
  parameter int COLOR_W           = 12,
  parameter int TRANSPARENT_KEY   = 0,
  localparam int TH_W             = (THEMES > 1) ? $clog2(THEMES) : 1
) (
  input  logic                         CLK,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [9:0]                   width,
  input  logic [9:0]                   height,
  input  logic [9:0]                   pos_x,
  input  logic [9:0]                   pos_y,
  input  logic [4:0]                   sprite_index,
  input  logic [TH_W-1:0]              theme,
  input  logic                         flip_x,
  input  logic                         key_en,
  output logic [SPRITEBUF_A_WIDTH-1:0] sprite_addr,
  input  logic [COLOR_W-1:0]           sprite_data,
  output logic                         fb_we,
  output logic [VRAM_A_WIDTH-1:0]      fb_addr,
  output logic [COLOR_W-1:0]           fb_data,
  input  logic                         fb_ready,
  output logic                         busy,
  output logic                         done
);

  state_t r_state;
  state_t w_next;

  // Draw parameters captured at start
  logic [9:0]      r_w, r_h, r_px, r_py;
  logic [4:0]      r_idx;
  logic [TH_W-1:0] r_theme;
  logic            r_key;
  logic            w_flip;

  // Scan counters
  logic [9:0] r_x, r_y;

  // Pipeline registers
  logic [SPRITEBUF_A_WIDTH-1:0] r_sprite_addr_p0;
  logic [VRAM_A_WIDTH-1:0]      r_fb_addr_p0, r_fb_addr_p1, r_fb_addr_p2;
  pipe_ctl_t                    r_ctl_p0, r_ctl_p1;
  logic [COLOR_W-1:0]           r_hold_data_p1;
  logic                         r_hold_vld_p1;
  logic                         r_we_p2;
  logic [COLOR_W-1:0]           r_data_p2;

  logic [SPRITEBUF_A_WIDTH-1:0] w_sprite_addr;
  logic [VRAM_A_WIDTH-1:0]      w_fb_addr;
  logic                         w_clip;
  logic                         w_stall;
  logic                         w_emit;
  logic                         w_last;
  logic                         w_start_ok;
  logic [COLOR_W-1:0]           w_pix_data;
  logic                         w_transparent;

  assign w_start_ok = (r_state == IDLE) && start;
  assign w_stall    = r_we_p2 && !fb_ready;
  assign w_emit     = (r_state == RUN) && !w_stall;
  assign w_last     = (r_x == r_w - 10'd1) && (r_y == r_h - 10'd1);

`ifdef DRAW_BLIT_FLIP_EN
  logic r_flip;
  // Capture the mirror request together with the other draw parameters
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_flip <= 1'b0;
    end else if (w_start_ok) begin
      r_flip <= flip_x;
    end
  end
  assign w_flip = r_flip;
`else
  logic w_unused_flip_x;
  assign w_unused_flip_x = flip_x;
  assign w_flip          = 1'b0;
`endif

  // Latch rectangle, sprite selection and key enable when a draw is accepted
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_w     <= '0;
      r_h     <= '0;
      r_px    <= '0;
      r_py    <= '0;
      r_idx   <= '0;
      r_theme <= '0;
      r_key   <= 1'b0;
    end else if (w_start_ok) begin
      r_w     <= width;
      r_h     <= height;
      r_px    <= pos_x;
      r_py    <= pos_y;
      r_idx   <= sprite_index;
      r_theme <= theme;
      r_key   <= key_en;
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state and status outputs
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = ((width == 10'd0) || (height == 10'd0)) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_emit && w_last) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (!r_ctl_p0.vld && !r_ctl_p1.vld && !w_stall) begin
          w_next = DONE;
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Raster counters: x fastest, then y; frozen during a stalled write
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_start_ok) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_emit) begin
      if (r_x == r_w - 10'd1) begin
        r_x <= '0;
        r_y <= r_y + 10'd1;
      end else begin
        r_x <= r_x + 10'd1;
      end
    end
  end

  draw_addr_gen #(
    .SCREEN_WIDTH      (SCREEN_WIDTH),
    .SCREEN_HEIGHT     (SCREEN_HEIGHT),
    .SPRITE_SIZE       (SPRITE_SIZE),
    .THEMES            (THEMES),
    .SPRITEBUF_A_WIDTH (SPRITEBUF_A_WIDTH),
    .VRAM_A_WIDTH      (VRAM_A_WIDTH),
    .TH_W              (TH_W)
  ) u_addr_gen (
    .i_x            (r_x),
    .i_y            (r_y),
    .i_pos_x        (r_px),
    .i_pos_y        (r_py),
    .i_sprite_index (r_idx),
    .i_theme        (r_theme),
    .i_flip_x       (w_flip),
    .o_sprite_addr  (w_sprite_addr),
    .o_fb_addr      (w_fb_addr),
    .o_clip         (w_clip)
  );

  // ---- stage p0: present sprite address, carry screen address and clip ----
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_sprite_addr_p0 <= '0;
      r_fb_addr_p0     <= '0;
      r_ctl_p0         <= '0;
    end else if (!w_stall) begin
      r_ctl_p0.vld <= w_emit;
      if (w_emit) begin
        r_sprite_addr_p0 <= w_sprite_addr;
        r_fb_addr_p0     <= w_fb_addr;
        r_ctl_p0.clip    <= w_clip;
      end
    end
  end

  // ---- stage p1: sprite_data for this slot arrives during this stage ----
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_fb_addr_p1 <= '0;
      r_ctl_p1     <= '0;
    end else if (!w_stall) begin
      r_fb_addr_p1 <= r_fb_addr_p0;
      r_ctl_p1     <= r_ctl_p0;
    end
  end

  // Keep the texel of the frozen p1 slot: the buffer returns it only on the
  // first stalled cycle, since sprite_addr already points at the next slot.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_hold_data_p1 <= '0;
      r_hold_vld_p1  <= 1'b0;
    end else if (w_stall && !r_hold_vld_p1) begin
      r_hold_data_p1 <= sprite_data;
      r_hold_vld_p1  <= 1'b1;
    end else if (!w_stall) begin
      r_hold_vld_p1  <= 1'b0;
    end
  end

  assign w_pix_data    = r_hold_vld_p1 ? r_hold_data_p1 : sprite_data;
  assign w_transparent = r_key && (w_pix_data == COLOR_W'(TRANSPARENT_KEY));

  // ---- stage p2: framebuffer write, held until fb_ready accepts it ----
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_we_p2      <= 1'b0;
      r_fb_addr_p2 <= '0;
      r_data_p2    <= '0;
    end else if (!w_stall) begin
      r_we_p2      <= r_ctl_p1.vld && !r_ctl_p1.clip && !w_transparent;
      r_fb_addr_p2 <= r_fb_addr_p1;
      r_data_p2    <= w_pix_data;
    end
  end

  assign sprite_addr = r_sprite_addr_p0;
  assign fb_we       = r_we_p2;
  assign fb_addr     = r_fb_addr_p2;
  assign fb_data     = r_data_p2;

endmodule

// File: tb/tb_draw_blit_engine.sv
// Self-checking bench for draw_blit_engine: directed scenarios plus random
// draws compared against a pixel-list reference model.
// Honours DRAW_BLIT_FLIP_EN for the expected mirroring behaviour.
module tb_draw_blit_engine;

  localparam int SW   = 320;
  localparam int SH   = 240;
  localparam int SS   = 32;
  localparam int TH   = 2;
  localparam int SA_W = 15;
  localparam int VA_W = 17;
  localparam int CW   = 12;

  logic            CLK = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [9:0]      width = '0, height = '0, pos_x = '0, pos_y = '0;
  logic [4:0]      sprite_index = '0;
  logic [0:0]      theme = '0;
  logic            flip_x = 1'b0, key_en = 1'b0;
  logic [SA_W-1:0] sprite_addr;
  logic [CW-1:0]   sprite_data = '0;
  logic            fb_we;
  logic [VA_W-1:0] fb_addr;
  logic [CW-1:0]   fb_data;
  logic            fb_ready = 1'b1;
  logic            busy, done;

  always #5 CLK = ~CLK;

  draw_blit_engine dut (
    .CLK(CLK), .rst_n(rst_n), .start(start),
    .width(width), .height(height), .pos_x(pos_x), .pos_y(pos_y),
    .sprite_index(sprite_index), .theme(theme), .flip_x(flip_x), .key_en(key_en),
    .sprite_addr(sprite_addr), .sprite_data(sprite_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
    .busy(busy), .done(done)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sprite buffer contents: encodes the address; key mode zeroes even texels
  logic key_mode = 1'b0;
  function automatic logic [CW-1:0] rom(input int a, input logic km);
    logic [31:0] av;
    av = a;
    if (km && !av[0]) return '0;
    return {av[10:0], 1'b1};
  endfunction

  always @(posedge CLK) sprite_data <= rom(int'(sprite_addr), key_mode);

  // Reference model: ordered list of expected framebuffer writes
  int exp_addr[$], exp_data[$];
  int obs_addr[$], obs_data[$];

  task automatic build_exp(input int w, h, px, py, idx, th, fl, ke, input logic km,
                           output int first_sa);
    int sx, sy, sa, d, fe;
`ifdef DRAW_BLIT_FLIP_EN
    fe = fl;
`else
    fe = 0;
`endif
    exp_addr.delete();
    exp_data.delete();
    first_sa = -1;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        sx = x % SS;
        if (fe != 0) sx = SS - 1 - sx;
        sy = y % SS;
        sa = ((idx * SS + sy) * SS * TH + th * SS + sx) % (1 << SA_W);
        if (x == 0 && y == 0) first_sa = sa;
        if (px + x >= SW || py + y >= SH) continue;
        d = int'(rom(sa, km));
        if (ke != 0 && d == 0) continue;
        exp_addr.push_back((SW * (py + y) + px + x) % (1 << VA_W));
        exp_data.push_back(d);
      end
    end
  endtask

  // Cycle bookkeeping and write/stall monitor, sampled on the falling edge
  int   cyc = 0;
  int   t0 = 0;
  int   ready_mode = 0;
  int   done_cnt = 0, done_cyc = -1, first_we = -1;
  logic prev_stall = 1'b0;
  logic [VA_W-1:0] prev_addr = '0;
  logic [CW-1:0]   prev_data = '0;

  initial forever begin
    @(negedge CLK);
    cyc++;
    if (prev_stall) begin
      check_eq("hold_we", 32'(fb_we), 32'd1);
      check_eq("hold_addr", 32'(fb_addr), 32'(prev_addr));
      check_eq("hold_data", 32'(fb_data), 32'(prev_data));
    end
    if (fb_we && fb_ready) begin
      obs_addr.push_back(int'(fb_addr));
      obs_data.push_back(int'(fb_data));
    end
    if (fb_we && first_we < 0) first_we = cyc;
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    prev_stall = fb_we && !fb_ready;
    prev_addr  = fb_addr;
    prev_data  = fb_data;
  end

  // fb_ready driver: always ready, random, or low for cycles 6..8 of a draw
  initial forever begin
    int k;
    @(posedge CLK);
    #1;
    k = cyc + 1 - t0;
    case (ready_mode)
      1:       fb_ready = ($urandom_range(0, 3) != 0);
      2:       fb_ready = !(k >= 6 && k <= 8);
      default: fb_ready = 1'b1;
    endcase
  end

  task automatic run_draw(input int w, h, px, py, idx, th, fl, ke, input logic km,
                          input int rmode, input bit chk_lat, input bit glitch);
    int first_sa, n, budget;
    bit got_done;
    build_exp(w, h, px, py, idx, th, fl, ke, km, first_sa);
    @(posedge CLK);
    #1;
    key_mode     = km;
    ready_mode   = rmode;
    width        = 10'(w);
    height       = 10'(h);
    pos_x        = 10'(px);
    pos_y        = 10'(py);
    sprite_index = 5'(idx);
    theme        = 1'(th);
    flip_x       = 1'(fl);
    key_en       = 1'(ke);
    start        = 1'b1;
    obs_addr.delete();
    obs_data.delete();
    done_cnt = 0;
    done_cyc = -1;
    first_we = -1;
    @(posedge CLK);
    t0 = cyc;
    #1;
    start = 1'b0;
    if (w > 0 && h > 0) begin
      @(negedge CLK);
      check_eq("busy_run", 32'(busy), 32'd1);
      @(negedge CLK);
      check_eq("first_sprite_addr", 32'(sprite_addr), 32'(first_sa));
      if (glitch) begin
        @(posedge CLK);
        #1;
        start = 1'b1;
        width = 10'd7;
        @(posedge CLK);
        #1;
        start = 1'b0;
        width = 10'(w);
      end
    end
    budget   = w * h * 8 + 100;
    got_done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (done_cnt > 0) begin
        got_done = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge CLK);
    if (!got_done) check_eq("done_timeout", 32'd0, 32'd1);
    check_eq("done_pulses", 32'(done_cnt), 32'd1);
    check_eq("busy_after", 32'(busy), 32'd0);
    check_eq("write_count", 32'(obs_addr.size()), 32'(exp_addr.size()));
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("fb_addr[%0d]", i), 32'(obs_addr[i]), 32'(exp_addr[i]));
      check_eq($sformatf("fb_data[%0d]", i), 32'(obs_data[i]), 32'(exp_data[i]));
    end
    if (chk_lat) check_eq("first_we_latency", 32'(first_we - t0), 32'd4);
    if (w == 0 || h == 0) check_eq("empty_done_latency", 32'(done_cyc - t0), 32'd1);
  endtask

  initial begin
    int w, h, px, py, idx, th, fl, ke;
    logic km;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_fb_we", 32'(fb_we), 32'd0);
    check_eq("rst_sprite_addr", 32'(sprite_addr), 32'd0);
    check_eq("rst_fb_addr", 32'(fb_addr), 32'd0);
    check_eq("rst_fb_data", 32'(fb_data), 32'd0);
    @(posedge CLK);
    #1;
    rst_n = 1'b1;
    @(negedge CLK);
    check_eq("post_rst_fb_we", 32'(fb_we), 32'd0);

    // Basic 4x2 rectangle at (10,5), sprite 1, theme 1
    run_draw(4, 2, 10, 5, 1, 1, 0, 0, 1'b0, 0, 1'b1, 1'b0);
    if (obs_addr.size() >= 5) begin
      check_eq("basic_addr_row0", 32'(obs_addr[0]), 32'd1610);
      check_eq("basic_addr_row0_end", 32'(obs_addr[3]), 32'd1613);
      check_eq("basic_addr_row1", 32'(obs_addr[4]), 32'd1930);
    end

    // Colour key: even texels are transparent
    run_draw(8, 2, 20, 30, 3, 0, 0, 1, 1'b1, 0, 1'b0, 1'b0);

    // Backpressure mid-line, with a start pulse while busy that must be ignored
    run_draw(8, 2, 0, 0, 2, 1, 0, 0, 1'b0, 2, 1'b1, 1'b1);

    // Horizontal clip at the right edge
    run_draw(4, 2, 318, 5, 0, 0, 0, 0, 1'b0, 0, 1'b1, 1'b0);

    // Empty rectangles
    run_draw(0, 3, 5, 5, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    run_draw(5, 0, 5, 5, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0);

    // Mirror across a full sprite width
    run_draw(SS, 1, 40, 7, 4, 1, 1, 0, 1'b0, 0, 1'b1, 1'b0);

    // Reset in the middle of a draw
    @(posedge CLK);
    #1;
    ready_mode = 0;
    width = 10'd20; height = 10'd4; pos_x = 10'd0; pos_y = 10'd0;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    rst_n = 1'b0;
    @(posedge CLK);
    #1;
    rst_n = 1'b1;
    @(negedge CLK);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_fb_we", 32'(fb_we), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_sprite_addr", 32'(sprite_addr), 32'd0);
    check_eq("abort_fb_addr", 32'(fb_addr), 32'd0);
    @(negedge CLK);
    check_eq("abort_fb_we_next", 32'(fb_we), 32'd0);
    check_eq("abort_busy_next", 32'(busy), 32'd0);
    run_draw(6, 3, 100, 100, 5, 0, 0, 0, 1'b0, 0, 1'b1, 1'b0);

    // Random draws under random backpressure
    for (int t = 0; t < 12; t++) begin
      w   = $urandom_range(0, 40);
      h   = $urandom_range(0, 6);
      px  = $urandom_range(0, 330);
      py  = $urandom_range(0, 245);
      idx = $urandom_range(0, 31);
      th  = $urandom_range(0, 1);
      fl  = $urandom_range(0, 1);
      ke  = $urandom_range(0, 1);
      km  = 1'($urandom_range(0, 1));
      run_draw(w, h, px, py, idx, th, fl, ke, km, 1, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
